// File: rtl/cpu_pkg.sv
// Shared brus16 CPU definitions: return-stack defaults and controller FSM states.
package cpu_pkg;

  localparam int RS_WIDTH      = 4;
  localparam int RS_SIZE       = 16;
  localparam int RS_DATA_WIDTH = 13;

  typedef enum logic {
    RS_RUN   = 1'b0,
    RS_FAULT = 1'b1
  } rs_state_t;

endpackage

// File: rtl/rstack.sv
// Return-stack storage: async-read / sync-write distributed RAM, not reset.
module rstack #(
  parameter int WIDTH      = cpu_pkg::RS_WIDTH,
  parameter int DATA_WIDTH = cpu_pkg::RS_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WIDTH-1:0]      waddr,
  input  logic [WIDTH-1:0]      raddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rstack_ctrl.sv
// Return-stack controller: owns the stack pointer, sequences rstack accesses,
// and freezes in FAULT on overflow/underflow until clear_fault.
module rstack_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH      = RS_WIDTH,
  parameter int SIZE       = RS_SIZE,
  parameter int DATA_WIDTH = RS_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  clear_fault,
  output logic [DATA_WIDTH-1:0] top,
  output logic [WIDTH:0]        depth,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  fault
);

  rs_state_t             state, nxt_state;
  logic [WIDTH:0]        rsp, nxt_rsp;
  logic                  nxt_ovf, nxt_udf;
  logic                  wr_req, we;
  logic [WIDTH-1:0]      waddr, raddr;
  logic [DATA_WIDTH-1:0] rdata;

  assign empty = (rsp == '0);
  assign full  = (rsp == (WIDTH+1)'(SIZE));
  assign raddr = rsp[WIDTH-1:0] - WIDTH'(1);

  always_comb begin
    nxt_state = state;
    nxt_rsp   = rsp;
    nxt_ovf   = overflow;
    nxt_udf   = underflow;
    wr_req    = 1'b0;
    waddr     = rsp[WIDTH-1:0];
    unique case (state)
      RS_RUN: begin
        if (clear_fault) begin
          nxt_rsp = '0;
        end else if (push && pop && !empty) begin
          wr_req = 1'b1;
          waddr  = raddr;
        end else if (push) begin
          // push+pop on an empty stack lands here as a plain push
          if (full) begin
            nxt_ovf   = 1'b1;
            nxt_state = RS_FAULT;
          end else begin
            wr_req  = 1'b1;
            nxt_rsp = rsp + 1'b1;
          end
        end else if (pop) begin
          if (empty) begin
            nxt_udf   = 1'b1;
            nxt_state = RS_FAULT;
          end else begin
            nxt_rsp = rsp - 1'b1;
          end
        end
      end
      RS_FAULT: begin
        if (clear_fault) begin
          nxt_rsp   = '0;
          nxt_ovf   = 1'b0;
          nxt_udf   = 1'b0;
          nxt_state = RS_RUN;
        end
      end
      default: nxt_state = RS_RUN;
    endcase
  end

  assign we = wr_req && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RS_RUN;
      rsp       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= nxt_state;
      rsp       <= nxt_rsp;
      overflow  <= nxt_ovf;
      underflow <= nxt_udf;
    end
  end

  rstack #(
    .WIDTH      (WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rstack (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .raddr (raddr),
    .wdata (din),
    .rdata (rdata)
  );

  assign top   = empty ? '0 : rdata;
  assign depth = rsp;
  assign fault = (state == RS_FAULT);

endmodule

// File: tb/tb_rstack_ctrl.sv
// Bench for rstack_ctrl: queue-based stack model compared every cycle, plus directed literals.
module tb_rstack_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [12:0] din = '0;
  logic        clear_fault = 1'b0;
  logic [12:0] top;
  logic [4:0]  depth;
  logic        empty, full, overflow, underflow, fault;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [12:0] q[$];
  bit m_ovf = 1'b0, m_udf = 1'b0, m_fault = 1'b0;

  always #5 clk = ~clk;

  rstack_ctrl #(.WIDTH(4), .SIZE(16), .DATA_WIDTH(13)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
    .clear_fault(clear_fault), .top(top), .depth(depth), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow), .fault(fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a plain stack of values, updated from the inputs at each edge.
  always @(posedge clk) begin
    if (reset) begin
      q.delete(); m_ovf = 0; m_udf = 0; m_fault = 0;
    end else if (m_fault) begin
      if (clear_fault) begin q.delete(); m_ovf = 0; m_udf = 0; m_fault = 0; end
    end else if (clear_fault) begin
      q.delete();
    end else if (push && pop && q.size() > 0) begin
      q[q.size()-1] = din;
    end else if (push) begin
      if (q.size() == 16) begin m_ovf = 1; m_fault = 1; end
      else q.push_back(din);
    end else if (pop) begin
      if (q.size() == 0) begin m_udf = 1; m_fault = 1; end
      else void'(q.pop_back());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_top",   32'(top),   (q.size() > 0) ? 32'(q[q.size()-1]) : 32'd0);
      check("model_depth", 32'(depth), 32'(q.size()));
      check("model_empty", 32'(empty), 32'(q.size() == 0));
      check("model_full",  32'(full),  32'(q.size() == 16));
      check("model_ovf",   32'(overflow),  32'(m_ovf));
      check("model_udf",   32'(underflow), 32'(m_udf));
      check("model_fault", 32'(fault),     32'(m_fault));
    end
  end

  task automatic step(input bit r, input bit p, input bit o, input logic [12:0] d, input bit c);
    reset = r; push = p; pop = o; din = d; clear_fault = c;
    @(posedge clk); #1;
    reset = 0; push = 0; pop = 0; clear_fault = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    check("rst_depth", 32'(depth), 0);
    check("rst_top", 32'(top), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_fault", 32'(fault), 0);

    step(0, 1, 0, 13'h0ABC, 0);
    step(0, 1, 0, 13'h1234, 0);
    check("push2_depth", 32'(depth), 2);
    check("push2_top", 32'(top), 32'h1234);
    step(0, 0, 1, 0, 0);
    check("pop1_top", 32'(top), 32'h0ABC);
    check("pop1_depth", 32'(depth), 1);
    step(0, 0, 1, 0, 0);
    check("pop2_empty", 32'(empty), 1);
    check("pop2_top", 32'(top), 0);

    for (int i = 0; i < 16; i++) step(0, 1, 0, 13'(i * 3), 0);
    check("fill_full", 32'(full), 1);
    check("fill_top", 32'(top), 45);
    step(0, 1, 0, 13'h1FFF, 0);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_fault", 32'(fault), 1);
    check("ovf_depth", 32'(depth), 16);
    check("ovf_mem0", 32'(dut.u_rstack.mem[0]), 0);
    step(0, 0, 0, 0, 1);
    check("clr_fault", 32'(fault), 0);
    check("clr_ovf", 32'(overflow), 0);
    check("clr_depth", 32'(depth), 0);

    step(0, 0, 1, 0, 0);
    check("udf_flag", 32'(underflow), 1);
    check("udf_fault", 32'(fault), 1);
    step(0, 1, 0, 13'h0123, 0);
    check("fault_push_depth", 32'(depth), 0);
    check("fault_push_fault", 32'(fault), 1);
    step(0, 0, 0, 0, 1);
    check("clr2_fault", 32'(fault), 0);
    check("clr2_udf", 32'(underflow), 0);

    step(0, 1, 0, 13'h0003, 0);
    step(0, 1, 0, 13'h0009, 0);
    step(0, 1, 0, 13'h0005, 0);
    check("d3_top", 32'(top), 5);
    step(0, 1, 1, 13'h0777, 0);
    check("repl_depth", 32'(depth), 3);
    check("repl_top", 32'(top), 32'h0777);
    step(0, 0, 1, 0, 0);
    check("repl_pop_top", 32'(top), 32'h0009);
    check("repl_pop_depth", 32'(depth), 2);

    step(0, 0, 0, 0, 1);
    check("flush_depth", 32'(depth), 0);
    step(0, 1, 1, 13'h0042, 0);
    check("pp_empty_depth", 32'(depth), 1);
    check("pp_empty_top", 32'(top), 32'h0042);
    check("pp_empty_udf", 32'(underflow), 0);

    for (int i = 1; i <= 4; i++) step(0, 1, 0, 13'(16'h0100 + i), 0);
    check("d5_depth", 32'(depth), 5);
    step(1, 1, 0, 13'h1555, 0);
    check("rstpush_depth", 32'(depth), 0);
    check("rstpush_top", 32'(top), 0);
    check("rstpush_mem5", 32'(dut.u_rstack.mem[5]), 15);

    for (int n = 0; n < 1000; n++) begin
      automatic int unsigned r = $urandom_range(0, 199);
      automatic bit p = $urandom_range(0, 1) == 1;
      automatic bit o = $urandom_range(0, 2) == 0;
      step(r == 0, p, o, 13'($urandom), r < 5 || (fault && r < 40));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
